mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
- Next-generation multicycle ARM-subset control unit: main FSM decoder and condition/flag logic merged into one block.
- Adds a variable-latency memory handshake, a memory timeout fault, and a parametrised ALUControl width (adds EOR/MOV).
- Sits beside the multicycle datapath and drives all of its mux selects and write enables.

Parameters:
ALUCTRL_W, 3, ALUControl width; 2 gives ADD/SUB/AND/ORR only, >=3 adds EOR and MOV.
MEM_TIMEOUT, 255, maximum wait cycles for MemReady before FAULT; 0 disables the timeout.
TO_W, 8, timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
Instr  in  20  instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
MemReady  in  1  memory completes the current access this cycle.
MemReq  out  1  memory access pending (FETCH, MEMRD, MEMWR).
PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  out  1 each  datapath enables and selects.
RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath selects.
ALUControl  out  ALUCTRL_W  ADD=0, SUB=1, AND=2, ORR=3, EOR=4, MOV=5.
Fault  out  1  sticky memory-timeout indication.
State  out  4  current FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): State=FETCH, Flags=0, CondExReg=0, timeout counter=0, Fault=0.
- While in reset, all write enables are 0 and MemReq=1.
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXECUTER(6), EXECUTEI(7), ALUWB(8), BRANCH(9), FAULT(15).
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - Holds until MemReady=1.
  - IRWrite=1 and PCWrite=1 only in the MemReady cycle; then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Evaluates Cond (standard 16 ARM codes) against the Flags register and registers the result into CondExReg.
  - Next state: Op=01 -> MEMADR; Op=10 -> BRANCH; Op=00 with Funct[5]=1 -> EXECUTEI; Op=00 with Funct[5]=0 -> EXECUTER; Op=11 -> FETCH (no writes).
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD. Next: Funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD: AdrSrc=1, MemReq=1; holds until MemReady, then MEMWB.
- MEMWR: AdrSrc=1, MemWrite=CondExReg every cycle; holds until MemReady, then FETCH.
- MEMWB: ResultSrc=01, RegWrite=CondExReg.
- EXECUTER: ALUSrcB=00. EXECUTEI: ALUSrcB=01. Both use ALUSrcA=00 and go to ALUWB.
  - Flags update at the end of EXECUTER/EXECUTEI when CondExReg=1: Funct[0]=1 updates N,Z; Funct[0]=1 with cmd ADD/SUB/CMP updates C,V.
- ALUWB: ResultSrc=00, RegWrite=CondExReg & ~NoWrite, where NoWrite = cmd CMP (1010).
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCWrite=CondExReg.
- PC-targeted writes: when Rd=15 in MEMWB or ALUWB, PCWrite=CondExReg and RegWrite=0.
- ALU decode (Funct[4:1]): 0100->ADD, 0010/1010->SUB, 0000->AND, 1100->ORR, 0001->EOR, 1101->MOV. Any other cmd gives ADD with no register write.
  - When ALUCTRL_W=2, EOR and MOV are treated as unsupported: no writes, no flag update.
- ImmSrc=Op. RegSrc[0]=(Op=10). RegSrc[1]=(Op=01 & Funct[0]=0). Both are combinational on Instr.
- Timeout counter: increments each cycle MemReq=1 and MemReady=0; clears on MemReady or on leaving the state.
  - When the count equals MEM_TIMEOUT (MEM_TIMEOUT>0), go to FAULT.
- FAULT: Fault=1, all enables 0, MemReq=0. Held until reset.
- MemReady is ignored outside FETCH/MEMRD/MEMWR.

Optional Feature:
MCCTRL_RETIRE_CNT_EN
- Defined: adds output RetireCount[31:0], reset 0. Increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or DECODE(Op=11), whether or not the condition passed. Wraps 0xFFFFFFFF->0. Frozen in FAULT.
- Undefined: no port and no counter logic.

Test Plan:
- MemReady=1 always, Instr[31:12]=0xE2821 (ADD R1,R2,#5) -> FETCH, DECODE, EXECUTEI, ALUWB in 4 cycles; RegWrite=1 in ALUWB; ALUControl=0.
- MemReady low for 3 cycles in FETCH -> IRWrite=0 for 3 cycles, IRWrite=1 and PCWrite=1 in cycle 4 only; then DECODE.
- SUBS gives Z=1, then Instr 0x1A000 (BNE) -> BRANCH with PCWrite=0; then 0x0A000 (BEQ) -> PCWrite=1.
- CMP (0xE3520) -> Flags updated, RegWrite=0 in ALUWB. STR (0xE5801) with MemReady after 2 waits -> MemWrite=1 for 3 cycles.
- MEM_TIMEOUT=4, MemReady held 0 in MEMRD -> FAULT after 4 wait cycles; Fault=1, State=15. reset=0 -> State=0 asynchronously.
- With MCCTRL_RETIRE_CNT_EN: 3 instructions executed -> RetireCount=3.

Source files
------------

// File: rtl/mc_ctrl_unit.sv
// Multicycle ARM-subset control unit: main FSM, ALU decode and condition/flag logic in one block.
// Optional feature macro: MCCTRL_RETIRE_CNT_EN adds the RetireCount output.
module mc_ctrl_unit #(
    parameter int ALUCTRL_W   = 3,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 MemReq,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Fault,
    output logic [3:0]           State
`ifdef MCCTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]          RetireCount
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd15
    } state_t;

    localparam bit HAS_EXT = (ALUCTRL_W >= 3);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_EOR = HAS_EXT ? ALUCTRL_W'(4) : ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_MOV = HAS_EXT ? ALUCTRL_W'(5) : ALUCTRL_W'(0);
    localparam logic [TO_W:0]        TO_LIMIT = (TO_W + 1)'(MEM_TIMEOUT);

    // Standard ARM condition evaluation against {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = ~z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = ~c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = ~n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = ~v;
            4'h8:    cond_pass = c & ~z;
            4'h9:    cond_pass = ~c | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = ~z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    state_t          state_r;
    logic [3:0]      flags_r;
    logic            condex_r;
    logic [TO_W-1:0] to_cnt_r;

    logic [3:0]           cond_s;
    logic [1:0]           op_s;
    logic [5:0]           funct_s;
    logic                 rd15_s;
    logic                 unused_rn_s;
    logic [ALUCTRL_W-1:0] alu_ctrl_s;
    logic                 alu_ok_s;
    logic                 no_write_s;
    logic                 cv_upd_s;
    logic                 wait_s;
    logic                 timeout_s;
    logic                 dp_wr_s;

    logic mem_req_s, pc_write_s, mem_write_s, reg_write_s, ir_write_s;

    assign cond_s      = Instr[19:16];
    assign op_s        = Instr[15:14];
    assign funct_s     = Instr[13:8];
    assign rd15_s      = (Instr[3:0] == 4'hF);
    assign unused_rn_s = ^Instr[7:4];

    // Data-processing command decode; unsupported commands map to ADD with no side effects.
    always_comb begin
        alu_ctrl_s = ALU_ADD;
        alu_ok_s   = 1'b0;
        no_write_s = 1'b0;
        cv_upd_s   = 1'b0;
        case (funct_s[4:1])
            4'b0100: begin alu_ctrl_s = ALU_ADD; alu_ok_s = 1'b1; cv_upd_s = 1'b1; end
            4'b0010: begin alu_ctrl_s = ALU_SUB; alu_ok_s = 1'b1; cv_upd_s = 1'b1; end
            4'b1010: begin
                alu_ctrl_s = ALU_SUB;
                alu_ok_s   = 1'b1;
                cv_upd_s   = 1'b1;
                no_write_s = 1'b1;
            end
            4'b0000: begin alu_ctrl_s = ALU_AND; alu_ok_s = 1'b1; end
            4'b1100: begin alu_ctrl_s = ALU_ORR; alu_ok_s = 1'b1; end
            4'b0001: begin alu_ctrl_s = ALU_EOR; alu_ok_s = HAS_EXT; end
            4'b1101: begin alu_ctrl_s = ALU_MOV; alu_ok_s = HAS_EXT; end
            default: begin alu_ctrl_s = ALU_ADD; alu_ok_s = 1'b0; end
        endcase
    end

    assign wait_s  = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    assign dp_wr_s = condex_r & alu_ok_s & ~no_write_s;

    // Timeout fires on the wait cycle whose count would reach MEM_TIMEOUT.
    always_comb begin
        if ((MEM_TIMEOUT > 0) && wait_s && !MemReady &&
            (({1'b0, to_cnt_r} + (TO_W + 1)'(1)) == TO_LIMIT)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Main FSM with flag, condition and timeout-counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_FETCH;
            flags_r  <= 4'h0;
            condex_r <= 1'b0;
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            if (wait_s && !MemReady && !timeout_s) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
            case (state_r)
                S_FETCH: begin
                    if (MemReady)       state_r <= S_DECODE;
                    else if (timeout_s) state_r <= S_FAULT;
                    else                state_r <= S_FETCH;
                end
                S_DECODE: begin
                    condex_r <= cond_pass(cond_s, flags_r);
                    case (op_s)
                        2'b01:   state_r <= S_MEMADR;
                        2'b10:   state_r <= S_BRANCH;
                        2'b00:   state_r <= funct_s[5] ? S_EXECUTEI : S_EXECUTER;
                        default: state_r <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_r <= funct_s[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (MemReady)       state_r <= S_MEMWB;
                    else if (timeout_s) state_r <= S_FAULT;
                    else                state_r <= S_MEMRD;
                end
                S_MEMWB: state_r <= S_FETCH;
                S_MEMWR: begin
                    if (MemReady)       state_r <= S_FETCH;
                    else if (timeout_s) state_r <= S_FAULT;
                    else                state_r <= S_MEMWR;
                end
                S_EXECUTER, S_EXECUTEI: begin
                    if (condex_r && funct_s[0] && alu_ok_s) begin
                        flags_r[3:2] <= ALUFlags[3:2];
                        if (cv_upd_s) flags_r[1:0] <= ALUFlags[1:0];
                    end
                    state_r <= S_ALUWB;
                end
                S_ALUWB:  state_r <= S_FETCH;
                S_BRANCH: state_r <= S_FETCH;
                S_FAULT:  state_r <= S_FAULT;
                default:  state_r <= S_FAULT;
            endcase
        end
    end

    // Per-state datapath controls decoded from the state register.
    always_comb begin
        mem_req_s   = 1'b0;
        pc_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        ir_write_s  = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALUControl  = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                ir_write_s = MemReady;
                pc_write_s = MemReady;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD: begin
                mem_req_s = 1'b1;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                pc_write_s  = condex_r & rd15_s;
                reg_write_s = condex_r & ~rd15_s;
            end
            S_MEMWR: begin
                mem_req_s   = 1'b1;
                AdrSrc      = 1'b1;
                mem_write_s = condex_r;
            end
            S_EXECUTER: ALUControl = alu_ctrl_s;
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctrl_s;
            end
            S_ALUWB: begin
                ALUControl  = alu_ctrl_s;
                pc_write_s  = dp_wr_s & rd15_s;
                reg_write_s = dp_wr_s & ~rd15_s;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pc_write_s = condex_r;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Reset forces every enable off and keeps the fetch request asserted.
    assign MemReq   = mem_req_s | ~reset;
    assign PCWrite  = pc_write_s & reset;
    assign MemWrite = mem_write_s & reset;
    assign RegWrite = reg_write_s & reset;
    assign IRWrite  = ir_write_s & reset;
    assign ImmSrc   = op_s;
    assign RegSrc   = {(op_s == 2'b01) & ~funct_s[0], (op_s == 2'b10)};
    assign Fault    = (state_r == S_FAULT);
    assign State    = state_r;

`ifdef MCCTRL_RETIRE_CNT_EN
    logic retire_s;

    // An instruction retires on any return to FETCH, taken or not.
    always_comb begin
        case (state_r)
            S_MEMWB, S_ALUWB, S_BRANCH: retire_s = 1'b1;
            S_MEMWR:                    retire_s = MemReady;
            S_DECODE:                   retire_s = (op_s == 2'b11);
            default:                    retire_s = 1'b0;
        endcase
    end

    // Free-running retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RetireCount <= 32'd0;
        end else if (retire_s) begin
            RetireCount <= RetireCount + 32'd1;
        end else begin
            RetireCount <= RetireCount;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: directed program plus random instructions against an ISA-level model.
module tb_mc_ctrl_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic        Fault;
    logic [3:0]  State;
`ifdef MCCTRL_RETIRE_CNT_EN
    logic [31:0] RetireCount;
`endif

    int   n_cmp = 0;
    int   n_mis = 0;
    logic n_m, z_m, c_m, v_m;
    int   retire_m;

    always #5 clk = ~clk;

    mc_ctrl_unit #(.ALUCTRL_W(3), .MEM_TIMEOUT(TMO), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .MemReq(MemReq), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .Fault(Fault), .State(State)
`ifdef MCCTRL_RETIRE_CNT_EN
        , .RetireCount(RetireCount)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Condition codes as pairs: odd code is the inverse of the even one below it.
    function automatic logic cond_ok(input logic [3:0] cond);
        logic base;
        case (cond[3:1])
            3'd0:    base = z_m;
            3'd1:    base = c_m;
            3'd2:    base = n_m;
            3'd3:    base = v_m;
            3'd4:    base = c_m && !z_m;
            3'd5:    base = (n_m == v_m);
            3'd6:    base = !z_m && (n_m == v_m);
            default: base = 1'b1;
        endcase
        return (cond == 4'hF) ? 1'b1 : (base ^ cond[0]);
    endfunction

    task automatic alu_ref(input logic [3:0] cmd, output int ctl, output logic ok,
                           output logic cmp, output logic cv);
        ok = 1'b1; cmp = 1'b0; cv = 1'b0;
        case (cmd)
            4'b0100: begin ctl = 0; cv = 1'b1; end
            4'b0010: begin ctl = 1; cv = 1'b1; end
            4'b1010: begin ctl = 1; cv = 1'b1; cmp = 1'b1; end
            4'b0000: ctl = 2;
            4'b1100: ctl = 3;
            4'b0001: ctl = 4;
            4'b1101: ctl = 5;
            default: begin ctl = 0; ok = 1'b0; end
        endcase
    endtask

    task automatic step(input string tag, input logic rdy, input logic [3:0] af, input int st,
                        input logic irw, input logic pcw, input logic mw, input logic rw,
                        input logic req, input logic adr, input int actl);
        MemReady = rdy;
        ALUFlags = af;
        #2;
        chk({tag, ".state"}, State, st);
        chk({tag, ".irwrite"}, IRWrite, irw);
        chk({tag, ".pcwrite"}, PCWrite, pcw);
        chk({tag, ".memwrite"}, MemWrite, mw);
        chk({tag, ".regwrite"}, RegWrite, rw);
        chk({tag, ".memreq"}, MemReq, req);
        chk({tag, ".adrsrc"}, AdrSrc, adr);
        chk({tag, ".fault"}, Fault, (st == 15));
        if (actl >= 0) chk({tag, ".aluctl"}, ALUControl, actl);
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; w1 >= TMO on a load models a memory that never answers.
    task automatic do_instr(input logic [19:0] ins, input logic [3:0] af, input int w0, input int w1);
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] fn;
        logic rd15, pass, ok, cmp, cv, wr;
        int ctl;
        cond = ins[19:16]; op = ins[15:14]; fn = ins[13:8]; rd15 = (ins[3:0] == 4'hF);
        Instr = ins;
        #1;
        chk("immsrc", ImmSrc, op);
        chk("regsrc", RegSrc, {(op == 2'b01) && !fn[0], op == 2'b10});
        for (int i = 0; i < w0; i++) step("fetch_wait", 1'b0, af, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step("fetch", 1'b1, af, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        pass = cond_ok(cond);
        step("decode", 1'($urandom), af, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        case (op)
            2'b10: step("branch", 1'($urandom), af, 9, 1'b0, pass, 1'b0, 1'b0, 1'b0, 1'b0, -1);
            2'b01: begin
                step("memadr", 1'($urandom), af, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
                if (fn[0]) begin
                    if (w1 >= TMO) begin
                        for (int i = 0; i < TMO; i++)
                            step("memrd_wait", 1'b0, af, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
                        step("fault", 1'b1, af, 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
                        return;
                    end
                    for (int i = 0; i < w1; i++)
                        step("memrd_wait", 1'b0, af, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
                    step("memrd", 1'b1, af, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
                    step("memwb", 1'($urandom), af, 4, 1'b0, pass && rd15, 1'b0, pass && !rd15, 1'b0, 1'b0, -1);
                end else begin
                    for (int i = 0; i < w1; i++)
                        step("memwr_wait", 1'b0, af, 5, 1'b0, 1'b0, pass, 1'b0, 1'b1, 1'b1, -1);
                    step("memwr", 1'b1, af, 5, 1'b0, 1'b0, pass, 1'b0, 1'b1, 1'b1, -1);
                end
            end
            2'b00: begin
                alu_ref(fn[4:1], ctl, ok, cmp, cv);
                step("exec", 1'($urandom), af, fn[5] ? 7 : 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ctl);
                if (pass && fn[0] && ok) begin
                    n_m = af[3]; z_m = af[2];
                    if (cv) begin c_m = af[1]; v_m = af[0]; end
                end
                wr = pass && ok && !cmp;
                step("aluwb", 1'($urandom), af, 8, 1'b0, wr && rd15, 1'b0, wr && !rd15, 1'b0, 1'b0, -1);
            end
            default: ;
        endcase
        retire_m++;
`ifdef MCCTRL_RETIRE_CNT_EN
        chk("retire", RetireCount, retire_m);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  cmds [7];
        logic [19:0] ins;
        logic [5:0]  fn;
        logic [1:0]  op;
        logic [3:0]  rd;
        cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b0001, 4'b1101};
        reset = 1'b0; MemReady = 1'b1; Instr = 20'h0; ALUFlags = 4'h0;
        {n_m, z_m, c_m, v_m} = 4'h0;
        retire_m = 0;
        @(posedge clk); #1;
        chk("rst.state", State, 0);
        chk("rst.memreq", MemReq, 1);
        chk("rst.irwrite", IRWrite, 0);
        chk("rst.pcwrite", PCWrite, 0);
        chk("rst.fault", Fault, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        do_instr(20'hE2821, 4'h0, 0, 0);      // ADD R1,R2,#5
        do_instr(20'hE2821, 4'h3, 3, 0);      // same, 3 fetch waits
        do_instr(20'hE2511, 4'b0100, 0, 0);   // SUBS -> Z=1
        do_instr(20'h1A000, 4'h0, 1, 0);      // BNE not taken
        do_instr(20'h0A000, 4'h0, 0, 0);      // BEQ taken
        do_instr(20'hE3520, 4'b1000, 0, 0);   // CMP -> N=1, no write
        do_instr(20'h4A000, 4'h0, 0, 0);      // BMI taken
        do_instr(20'hE5801, 4'h0, 0, 2);      // STR, 2 memory waits
        do_instr(20'hE591F, 4'h0, 2, 1);      // LDR PC
        do_instr(20'hEC000, 4'h0, 0, 0);      // Op=11, no writes

        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            rd = 4'($urandom);
            if (op == 2'b00) begin
                fn[4:1] = cmds[$urandom_range(0, 6)];
                if (fn[4:1] == 4'b1010 && rd == 4'hF) rd = 4'h0;
            end
            ins = {4'($urandom), op, fn, 4'($urandom), rd};
            do_instr(ins, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        do_instr(20'hE5910, 4'h0, 0, TMO);    // LDR with a memory that never answers
        step("fault_hold", 1'b1, 4'h0, 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        step("fault_hold", 1'b0, 4'h0, 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        reset = 1'b0;
        #1;
        chk("async_rst.state", State, 0);
        chk("async_rst.fault", Fault, 0);
        chk("async_rst.memreq", MemReq, 1);
        {n_m, z_m, c_m, v_m} = 4'h0;
        retire_m = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        do_instr(20'hE2821, 4'h0, 0, 0);
        do_instr(20'hE5801, 4'h0, 1, 1);
        do_instr(20'h0A000, 4'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
